mem_access_unit: RTL

Parametrised load/store unit between the CPU data port and a byte-wide synchronous data RAM. It replaces the fixed byte-read, sign-extend-to-32-bit path with three features:
- byte, halfword, word (and doubleword when `DATA_W` allows) accesses, serialised into little-endian byte transfers;
- sign or zero extension on loads;
- a request/done handshake, so the CPU stalls on multi-cycle accesses.

---
 rtl/mem_access_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit serialising 1/2/4/8-byte CPU accesses into byte RAM cycles; MEM_ACCESS_MISALIGN_TRAP_EN rejects misaligned accesses.
// Latency: store done N+1, load done N+2 cycles after acceptance; CPU stalls via busy, req ignored unless idle.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, wsh;
  logic [2:0]          cnt, last_idx;
  logic                err_pend;
  logic                p1_vld, p2_vld;
  logic [2:0]          p1_idx, p2_idx;
  logic [DATA_W-1:0]   shreg, asm_dat, ext_dat;
  logic                illegal, accept, sbit;
  int                  nb8;

  assign last_idx = 3'((4'd1 << size_q) - 4'd1);
  assign accept   = (state == IDLE) && req && !err_pend;
  assign wsh      = wdata_q >> {cnt, 3'b000};

  always_comb begin
    illegal = ((32'd8 << size) > DATA_W);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if ((addr[2:0] & 3'((4'd1 << size) - 4'd1)) != 3'd0) illegal = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !illegal) state_nxt = XFER;
      XFER:    if (cnt == last_idx) state_nxt = we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read bytes arrive two edges after issue; merge the arriving lane so RESP sees the last byte.
  always_comb begin
    asm_dat = shreg;
    for (int k = 0; k < DATA_W / 8; k++)
      if (p2_vld && p2_idx == 3'(k)) asm_dat[8*k +: 8] = ram_rdata;
  end

  always_comb begin
    nb8  = 8 << size_q;
    sbit = asm_dat[nb8-1];
    for (int b = 0; b < DATA_W; b++)
      ext_dat[b] = (b < nb8) ? asm_dat[b] : (sbit & ~uns_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= 3'd0;
      err_pend  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= 8'd0;
      ram_we    <= 1'b0;
      p1_vld    <= 1'b0;
      p1_idx    <= 3'd0;
      p2_vld    <= 1'b0;
      p2_idx    <= 3'd0;
      shreg     <= '0;
    end else begin
      err_pend <= accept && illegal;
      err      <= err_pend;
      busy     <= (state == XFER) || (state == WAIT);
      done     <= (state == RESP);
      ram_we   <= 1'b0;
      p1_vld   <= 1'b0;
      p2_vld   <= p1_vld;
      p2_idx   <= p1_idx;
      if (p2_vld) shreg <= asm_dat;
      if (accept && !illegal) begin
        we_q    <= we;
        uns_q   <= uns;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= 3'd0;
      end
      if (state == XFER) begin
        ram_addr  <= addr_q + ADDR_W'(cnt);
        ram_we    <= we_q;
        ram_wdata <= wsh[7:0];
        p1_vld    <= !we_q;
        p1_idx    <= cnt;
        cnt       <= cnt + 3'd1;
      end
      if (state == RESP && !we_q) rdata <= ext_dat;
    end
  end

endmodule
